// File: rtl/matvec_stream_engine.sv
// Streaming y = A*x engine: x loaded once, rows streamed one per cycle, row-to-writeback latency clog2(N)+2.
// Backpressure: row_ready only in ROWS, vec_ready only in IDLE; out_vec held in OUT until out_ready.
module matvec_stream_engine #(
  parameter int M    = 16,
  parameter int N    = 16,
  parameter int DW   = 32,
  parameter int FRAC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW*N-1:0] vec_in,
  input  logic            vec_acc,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [DW*N-1:0] row_in,
  input  logic            row_valid,
  output logic            row_ready,
  output logic [DW*M-1:0] out_vec,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int LG    = $clog2(N);
  localparam int PW    = 2 * DW;
  localparam int ACC_W = PW + LG;
  localparam int TW    = (M > 1) ? $clog2(M) : 1;
  localparam logic [TW-1:0] LAST = TW'(M - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROWS, S_DRAIN, S_OUT} state_t;

  state_t                  r_state;
  logic                    r_vec_rdy;
  logic                    r_row_rdy;
  logic                    r_out_vld;
  logic [TW-1:0]           r_cnt;
  logic                    r_acc;
  logic                    r_done;
  logic signed [DW-1:0]    r_vec    [N];
  logic signed [DW-1:0]    r_in_row [N];
  logic                    r_in_vld;
  logic [TW-1:0]           r_in_tag;
  logic signed [ACC_W-1:0] r_lvl    [LG+1][N];
  logic [LG:0]             r_pvld;
  logic [TW-1:0]           r_ptag   [LG+1];
  logic signed [DW-1:0]    r_out    [M];

  logic                    w_vec_hs;
  logic                    w_row_hs;
  logic                    w_out_hs;
  logic signed [PW-1:0]    w_prod   [N];
  logic signed [DW-1:0]    w_res;

  assign w_vec_hs  = vec_valid && r_vec_rdy;
  assign w_row_hs  = row_valid && r_row_rdy;
  assign w_out_hs  = out_ready && r_out_vld;
  assign vec_ready = r_vec_rdy;
  assign row_ready = r_row_rdy;
  assign out_valid = r_out_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vec_rdy <= 1'b1;
      r_row_rdy <= 1'b0;
      r_out_vld <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_vec_hs) begin
            r_state   <= S_ROWS;
            r_vec_rdy <= 1'b0;
            r_row_rdy <= 1'b1;
            r_cnt     <= '0;
            r_acc     <= vec_acc;
          end
        end
        S_ROWS: begin
          if (w_row_hs) begin
            r_cnt <= r_cnt + TW'(1);
            if (r_cnt == LAST) begin
              r_state   <= S_DRAIN;
              r_row_rdy <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // r_done rises on the writeback edge of the last row, so OUT starts one cycle later
          if (r_done) begin
            r_state   <= S_OUT;
            r_out_vld <= 1'b1;
          end
        end
        S_OUT: begin
          if (w_out_hs) begin
            r_state   <= S_IDLE;
            r_out_vld <= 1'b0;
            r_vec_rdy <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_vec_hs) begin
      for (int j = 0; j < N; j++) r_vec[j] <= vec_in[j*DW +: DW];
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) w_prod[j] = PW'(r_in_row[j]) * PW'(r_vec[j]);
  end

  // Datapath registers carry no reset; only the valid bits below qualify them.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) r_in_row[j] <= row_in[j*DW +: DW];
    r_in_tag <= r_cnt;
    for (int j = 0; j < N; j++) r_lvl[0][j] <= ACC_W'(w_prod[j]);
    r_ptag[0] <= r_in_tag;
    for (int k = 1; k <= LG; k++) begin
      for (int j = 0; j < N / 2; j++) r_lvl[k][j] <= r_lvl[k-1][2*j] + r_lvl[k-1][2*j+1];
      for (int j = N / 2; j < N; j++) r_lvl[k][j] <= '0;
      r_ptag[k] <= r_ptag[k-1];
    end
  end

  assign w_res = DW'(r_lvl[LG][0] >>> FRAC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_vld <= 1'b0;
      r_pvld   <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < M; i++) r_out[i] <= '0;
    end else begin
      r_in_vld <= w_row_hs;
      r_pvld   <= {r_pvld[LG-1:0], r_in_vld};
      if (w_vec_hs) begin
        r_done <= 1'b0;
      end else if (r_pvld[LG] && (r_ptag[LG] == LAST)) begin
        r_done <= 1'b1;
      end
      for (int i = 0; i < M; i++) begin
        if (r_pvld[LG] && (r_ptag[LG] == TW'(i))) begin
          r_out[i] <= r_acc ? (r_out[i] + w_res) : w_res;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < M; i++) out_vec[i*DW +: DW] = r_out[i];
  end

endmodule

// File: tb/tb_matvec_stream_engine.sv
module tb_matvec_stream_engine;
  localparam int M  = 16;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int L  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [DW*N-1:0] vec_in, row_in;
  logic            vec_acc, vec_valid, row_valid, out_ready;
  logic            vec_ready, row_ready, out_valid;
  logic [DW*M-1:0] out_vec;

  logic [DW*N-1:0] f_vec_in, f_row_in;
  logic            f_vec_valid, f_row_valid, f_out_ready;
  logic            f_vec_ready, f_row_ready, f_out_valid;
  logic [DW-1:0]   f_out_vec;

  int total = 0;
  int bad   = 0;

  matvec_stream_engine #(.M(M), .N(N), .DW(DW), .FRAC(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .vec_in(vec_in), .vec_acc(vec_acc), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready)
  );

  matvec_stream_engine #(.M(1), .N(N), .DW(DW), .FRAC(8)) u_frac (
    .clk(clk), .rst_n(rst_n),
    .vec_in(f_vec_in), .vec_acc(1'b0), .vec_valid(f_vec_valid), .vec_ready(f_vec_ready),
    .row_in(f_row_in), .row_valid(f_row_valid), .row_ready(f_row_ready),
    .out_vec(f_out_vec), .out_valid(f_out_valid), .out_ready(f_out_ready)
  );

  typedef struct {
    int          kind;   // 0 identity with x=1..N, 1 only row 0 nonzero, 2 uniform matrix
    logic [31:0] xv;
    logic [31:0] av;
    bit          acc;
    logic [31:0] e0;
    logic [31:0] er;
  } rec_t;

  rec_t tbl [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*N-1:0] mk_vec(input int kind, input logic [31:0] xv);
    logic [DW*N-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = (kind == 0) ? 32'(j + 1) : xv;
    return v;
  endfunction

  function automatic logic [DW*N-1:0] mk_row(input int kind, input logic [31:0] av, input int r);
    logic [DW*N-1:0] v;
    for (int j = 0; j < N; j++) begin
      case (kind)
        0:       v[j*DW +: DW] = (j == r) ? 32'd1 : 32'd0;
        1:       v[j*DW +: DW] = (r == 0) ? av : 32'd0;
        default: v[j*DW +: DW] = av;
      endcase
    end
    return v;
  endfunction

  task automatic do_gemv(input int kind, input logic [31:0] xv, input logic [31:0] av,
                         input bit acc, input bit noisy, input int hold, input int abort,
                         input logic [31:0] e0, input logic [31:0] er, input string nm);
    int cyc, rows, guard, extra;
    bit hs, held;
    logic [DW*M-1:0] snap;
    logic [31:0] exp;
    vec_in    = mk_vec(kind, xv);
    vec_acc   = acc;
    vec_valid = 1'b1;
    out_ready = (hold == 0);
    guard     = 0;
    while (!vec_ready && guard < 50) begin
      step();
      guard++;
    end
    check({nm, " vec_ready"}, vec_ready, 1);
    step();
    // Illegal traffic: a different vector offered while busy must never be taken
    vec_valid = noisy;
    vec_in    = '1;
    vec_acc   = ~acc;
    cyc = 0; rows = 0; guard = 0;
    while (rows < M && guard < 400) begin
      row_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      row_in    = mk_row(kind, av, rows);
      hs        = row_valid && row_ready;
      step();
      cyc++;
      guard++;
      if (hs) rows++;
      if (abort > 0 && rows == abort) break;
    end
    if (abort > 0) begin
      rst_n     = 1'b0;
      row_valid = 1'b0;
      vec_valid = 1'b0;
      step();
      check({nm, " rst vec_ready"}, vec_ready, 1);
      check({nm, " rst row_ready"}, row_ready, 0);
      check({nm, " rst out_valid"}, out_valid, 0);
      check({nm, " rst out_vec"}, (out_vec == '0), 1);
      rst_n = 1'b1;
      return;
    end
    check({nm, " rows"}, rows, M);
    row_valid = noisy;
    row_in    = '1;
    extra = 0; guard = 0;
    while (!out_valid && guard < 100) begin
      if (row_valid && row_ready) extra++;
      step();
      cyc++;
      guard++;
    end
    check({nm, " out_valid"}, out_valid, 1);
    if (!noisy) check({nm, " latency"}, cyc, 1 + M + L);
    snap = out_vec;
    held = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (row_valid && row_ready) extra++;
      step();
      if (!out_valid || out_vec !== snap) held = 1'b0;
    end
    if (hold > 0) check({nm, " held"}, held, 1);
    check({nm, " extra rows"}, extra, 0);
    for (int i = 0; i < M; i++) begin
      exp = (kind == 0) ? 32'(i + 1) : ((i == 0) ? e0 : er);
      check($sformatf("%s y[%0d]", nm, i), out_vec[i*DW +: DW], exp);
    end
    out_ready = 1'b1;
    step();
    vec_valid = 1'b0;
    row_valid = 1'b0;
    check({nm, " post out_valid"}, out_valid, 0);
    check({nm, " post vec_ready"}, vec_ready, 1);
  endtask

  initial begin
    int cnt, guard, cyc;
    bit ok;
    tbl[0] = '{0, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0};
    tbl[1] = '{1, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFEB0, 32'h0};
    tbl[2] = '{2, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h10,       32'h10};
    tbl[3] = '{2, 32'd2,        32'd1,        1'b0, 32'd32,       32'd32};
    tbl[4] = '{2, 32'd2,        32'd1,        1'b1, 32'd64,       32'd64};
    tbl[5] = '{2, 32'd2,        32'd1,        1'b0, 32'd32,       32'd32};
    tbl[6] = '{2, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFA0, 32'hFFFFFFA0};

    rst_n = 1'b0;
    vec_in = '0; vec_acc = 1'b0; vec_valid = 1'b0;
    row_in = '0; row_valid = 1'b0; out_ready = 1'b1;
    f_vec_in = '0; f_vec_valid = 1'b0; f_row_in = '0; f_row_valid = 1'b0; f_out_ready = 1'b0;
    step();
    step();
    check("reset vec_ready", vec_ready, 1);
    check("reset row_ready", row_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_vec", (out_vec == '0), 1);
    rst_n = 1'b1;
    step();

    do_gemv(2, 32'd2, 32'd1, 1'b1, 1'b0, 0, 0, 32'd32, 32'd32, "acc_from_reset");

    for (int t = 0; t < 7; t++) begin
      do_gemv(tbl[t].kind, tbl[t].xv, tbl[t].av, tbl[t].acc, 1'b0, 0, 0,
              tbl[t].e0, tbl[t].er, $sformatf("vec%0d", t));
    end

    do_gemv(2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 10, 0, 32'hFFFFFFA0, 32'hFFFFFFA0, "noisy");

    row_valid = 1'b1;
    row_in    = '1;
    ok        = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (row_ready || !vec_ready || out_valid) ok = 1'b0;
    end
    row_valid = 1'b0;
    check("idle rows ignored", ok, 1);
    check("idle out_vec kept", out_vec[31:0], 32'hFFFFFFA0);

    do_gemv(0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 5, 32'h0, 32'h0, "abort");
    do_gemv(0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, "after_abort");

    // Single-row, FRAC=8 build
    for (int j = 0; j < N; j++) begin
      f_vec_in[j*DW +: DW] = 32'd256;
      f_row_in[j*DW +: DW] = 32'd256;
    end
    check("frac vec_ready", f_vec_ready, 1);
    f_vec_valid = 1'b1;
    step();
    f_vec_valid = 1'b0;
    check("frac row_ready", f_row_ready, 1);
    f_row_valid = 1'b1;
    cnt = 0; guard = 0; cyc = 0;
    while (!f_out_valid && guard < 50) begin
      if (f_row_valid && f_row_ready) cnt++;
      step();
      cyc++;
      guard++;
    end
    check("frac out_valid", f_out_valid, 1);
    check("frac rows", cnt, 1);
    check("frac latency", cyc, 1 + 1 + L);
    check("frac y0", f_out_vec, 32'd4096);
    f_row_valid = 1'b0;
    f_out_ready = 1'b1;
    step();
    check("frac post out_valid", f_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
